// File: rtl/non_stop_etc_multilane.sv
// Multi-lane non-stop ETC controller: each lane queues reader verdicts between
// the E-pass reader and the barrier, with operator override, closing gap and statistics.
module non_stop_etc_multilane #(
  parameter int LANES     = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16,
  parameter int CLOSE_GAP = 3,
  parameter int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       sensor1,
  input  logic [LANES-1:0]       sensor2,
  input  logic [LANES-1:0]       sensor3,
  input  logic [2*LANES-1:0]     valid_Epass,
  input  logic [LANES-1:0]       enable,
  output logic [LANES-1:0]       barrier,
  output logic [LANES-1:0]       low_bal,
  output logic [LANES-1:0]       err,
  output logic [LVL_W*LANES-1:0] q_level,
  output logic [LVL_W*LANES-1:0] occ,
  output logic [CNT_W*LANES-1:0] pass_cnt,
  output logic [CNT_W*LANES-1:0] fail_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int GAP_W = (CLOSE_GAP < 1) ? 1 : $clog2(CLOSE_GAP + 1);
  localparam logic [LVL_W-1:0] OCC_MAX = {LVL_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic             s1_q, s2_q, s3_q, en_q;
    logic [1:0]       cap_q, cap_d;
    logic [1:0]       mem_q [DEPTH];
    logic [1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d, occ_q, occ_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] pc_q, pc_d, fc_q, fc_d;
    logic             bar_q, bar_d, err_q, err_d;
    logic [1:0]       code, head, entry;
    logic             s1_rise, s2_fall, s3_fall, en_rise;
    logic             empty, full, ovr, pop, push, head_pass_eff, occ_unf;

    // Queue entries are {pass, low}; head decisions use the state at the start of the cycle
    always_comb begin
      code          = valid_Epass[2*i +: 2];
      s1_rise       = sensor1[i] & ~s1_q;
      s2_fall       = s2_q & ~sensor2[i];
      s3_fall       = s3_q & ~sensor3[i];
      en_rise       = enable[i] & ~en_q;
      empty         = (lvl_q == {LVL_W{1'b0}});
      full          = (lvl_q == LVL_W'(DEPTH));
      head          = mem_q[rd_q];
      ovr           = en_rise & ~empty & ~head[1];
      head_pass_eff = head[1] | ovr;
      pop           = s3_fall & ~empty;
      push          = s2_fall & (~full | pop);
      entry         = {cap_q[1], (cap_q == 2'b11)};
      occ_unf       = 1'b0;
      occ_d         = occ_q;
      lvl_d         = lvl_q;

      cap_d = s2_fall ? 2'b00 :
              ((sensor2[i] & (cap_q == 2'b00) & (code != 2'b00)) ? code : cap_q);

      // A push into the slot being popped must win over an override of that same slot
      for (int j = 0; j < DEPTH; j++) begin
        mem_d[j] = (push && (wr_q == PTR_W'(j))) ? entry :
                   ((ovr && (rd_q == PTR_W'(j))) ? 2'b10 : mem_q[j]);
      end

      rd_d = pop  ? rd_q + PTR_W'(1) : rd_q;
      wr_d = push ? wr_q + PTR_W'(1) : wr_q;

      case ({push, pop})
        2'b10:   lvl_d = lvl_q + LVL_W'(1);
        2'b01:   lvl_d = lvl_q - LVL_W'(1);
        default: lvl_d = lvl_q;
      endcase

      case ({s1_rise, s3_fall})
        2'b10:   occ_d = (occ_q == OCC_MAX) ? occ_q : occ_q + LVL_W'(1);
        2'b01: begin
          occ_d   = (occ_q == {LVL_W{1'b0}}) ? occ_q : occ_q - LVL_W'(1);
          occ_unf = (occ_q == {LVL_W{1'b0}});
        end
        default: occ_d = occ_q;
      endcase

      pc_d = (pop & head_pass_eff & (pc_q != CNT_MAX)) ? pc_q + CNT_W'(1) : pc_q;
      fc_d = (pop & ~head_pass_eff & (fc_q != CNT_MAX)) ? fc_q + CNT_W'(1) : fc_q;

      gap_d = pop ? GAP_W'(CLOSE_GAP) :
              ((gap_q != GAP_W'(0)) ? gap_q - GAP_W'(1) : gap_q);
      bar_d = s3_fall ? 1'b0 : (~empty & head[1] & (gap_q == GAP_W'(0)));
      err_d = err_q | (s2_fall & full & ~pop) | (s3_fall & empty) | occ_unf;
    end

    // Lane state register
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        s3_q  <= 1'b0;
        en_q  <= 1'b0;
        cap_q <= 2'b00;
        rd_q  <= {PTR_W{1'b0}};
        wr_q  <= {PTR_W{1'b0}};
        lvl_q <= {LVL_W{1'b0}};
        occ_q <= {LVL_W{1'b0}};
        gap_q <= {GAP_W{1'b0}};
        pc_q  <= {CNT_W{1'b0}};
        fc_q  <= {CNT_W{1'b0}};
        bar_q <= 1'b0;
        err_q <= 1'b0;
        for (int j = 0; j < DEPTH; j++) mem_q[j] <= 2'b00;
      end else begin
        s1_q  <= sensor1[i];
        s2_q  <= sensor2[i];
        s3_q  <= sensor3[i];
        en_q  <= enable[i];
        cap_q <= cap_d;
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        lvl_q <= lvl_d;
        occ_q <= occ_d;
        gap_q <= gap_d;
        pc_q  <= pc_d;
        fc_q  <= fc_d;
        bar_q <= bar_d;
        err_q <= err_d;
        for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
      end
    end

    assign barrier[i]                  = bar_q;
    assign low_bal[i]                  = ~empty & head[1] & head[0];
    assign err[i]                      = err_q;
    assign q_level[i*LVL_W +: LVL_W]   = lvl_q;
    assign occ[i*LVL_W +: LVL_W]       = occ_q;
    assign pass_cnt[i*CNT_W +: CNT_W]  = pc_q;
    assign fail_cnt[i*CNT_W +: CNT_W]  = fc_q;
  end

endmodule

// File: tb/tb_non_stop_etc_multilane.sv
// Directed bench for non_stop_etc_multilane: cycle table for the basic flows,
// then hand-written sequences for override, gap, overflow, errors, saturation and reset.
module tb_non_stop_etc_multilane;
  localparam int LANES     = 2;
  localparam int DEPTH     = 2;
  localparam int CNT_W     = 2;
  localparam int CLOSE_GAP = 3;
  localparam int LVL_W     = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] s1, s2, s3, en;
  logic [3:0] code;
  logic [1:0] barrier, low_bal, err;
  logic [3:0] q_level, occ, pass_cnt, fail_cnt;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [1:0] s1, s2, s3, en;
    logic [3:0] code;
    logic [1:0] bar, lb, er;
    logic [3:0] lvl, oc, pc, fc;
  } vec_t;

  vec_t tbl [19];

  always #5 clk = ~clk;

  non_stop_etc_multilane #(
    .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W), .CLOSE_GAP(CLOSE_GAP)
  ) dut (
    .clk(clk), .reset(reset), .sensor1(s1), .sensor2(s2), .sensor3(s3),
    .valid_Epass(code), .enable(en), .barrier(barrier), .low_bal(low_bal),
    .err(err), .q_level(q_level), .occ(occ), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  function automatic vec_t mk(input logic [1:0] i1, input logic [1:0] i2, input logic [1:0] i3,
                              input logic [1:0] ie, input logic [3:0] ic, input logic [1:0] b,
                              input logic [1:0] l, input logic [1:0] e, input logic [3:0] q,
                              input logic [3:0] o, input logic [3:0] p, input logic [3:0] f);
    vec_t v;
    v.s1 = i1; v.s2 = i2; v.s3 = i3; v.en = ie; v.code = ic;
    v.bar = b; v.lb = l; v.er = e; v.lvl = q; v.oc = o; v.pc = p; v.fc = f;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic s1_pulse(input int l);
    s1[l] = 1'b1; step();
    s1[l] = 1'b0; step();
  endtask

  // s2 high for five cycles, code presented on the 2nd; returns just after the push edge
  task automatic s2_window(input int l, input logic [1:0] c);
    s2[l] = 1'b1; code[2*l +: 2] = 2'b00; step();
    code[2*l +: 2] = c; step();
    code[2*l +: 2] = 2'b00; step(); step(); step();
    s2[l] = 1'b0; step();
  endtask

  task automatic s3_pulse(input int l);
    s3[l] = 1'b1; step();
    s3[l] = 1'b0; step();
  endtask

  initial begin
    //             s1     s2     s3     en    code   bar    lb     err   lvl   occ   pc    fc
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[1]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[2]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 4'h2, 2'b00, 2'b00, 2'b00, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[3]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 4'h2, 2'b00, 2'b00, 2'b00, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[4]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[5]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[6]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0);
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b01, 2'b00, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0);
    tbl[8]  = mk(2'b00, 2'b00, 2'b01, 2'b00, 4'h0, 2'b01, 2'b00, 2'b00, 4'h1, 4'h1, 4'h0, 4'h0);
    tbl[9]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'h1, 4'h0);
    tbl[10] = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'h1, 4'h0);
    tbl[11] = mk(2'b11, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h5, 4'h1, 4'h0);
    tbl[12] = mk(2'b00, 2'b11, 2'b00, 2'b00, 4'h7, 2'b00, 2'b00, 2'b00, 4'h0, 4'h5, 4'h1, 4'h0);
    tbl[13] = mk(2'b00, 2'b11, 2'b00, 2'b00, 4'hA, 2'b00, 2'b00, 2'b00, 4'h0, 4'h5, 4'h1, 4'h0);
    tbl[14] = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b01, 2'b00, 4'h5, 4'h5, 4'h1, 4'h0);
    tbl[15] = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b01, 2'b01, 2'b00, 4'h5, 4'h5, 4'h1, 4'h0);
    tbl[16] = mk(2'b00, 2'b00, 2'b11, 2'b00, 4'h0, 2'b01, 2'b01, 2'b00, 4'h5, 4'h5, 4'h1, 4'h0);
    tbl[17] = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'h2, 4'h4);
    tbl[18] = mk(2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'h2, 4'h4);

    s1 = 2'b00; s2 = 2'b00; s3 = 2'b00; en = 2'b00; code = 4'h0;
    reset = 1'b1;
    step(); step();
    chk("reset_state", 32'({barrier, low_bal, err, q_level, occ, pass_cnt, fail_cnt}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      s1 = tbl[i].s1; s2 = tbl[i].s2; s3 = tbl[i].s3; en = tbl[i].en; code = tbl[i].code;
      step();
      chk($sformatf("vec%0d", i),
          32'({barrier, low_bal, err, q_level, occ, pass_cnt, fail_cnt}),
          32'({tbl[i].bar, tbl[i].lb, tbl[i].er, tbl[i].lvl, tbl[i].oc, tbl[i].pc, tbl[i].fc}));
    end

    // Override of a FAIL head
    s1_pulse(0); s2_window(0, 2'b00);
    chk("ovr_qlvl", 32'(q_level[1:0]), 32'd1);
    chk("ovr_bar_wait", 32'(barrier[0]), 32'd0);
    step(); step();
    chk("ovr_bar_hold", 32'(barrier[0]), 32'd0);
    en[0] = 1'b1; step();
    chk("ovr_bar_edge", 32'(barrier[0]), 32'd0);
    en[0] = 1'b0; step();
    chk("ovr_bar_open", 32'(barrier[0]), 32'd1);
    chk("ovr_lowbal", 32'(low_bal[0]), 32'd0);
    s3_pulse(0);
    chk("ovr_pass", 32'(pass_cnt[1:0]), 32'd3);
    chk("ovr_fail", 32'(fail_cnt[1:0]), 32'd0);
    chk("ovr_bar_pop", 32'(barrier[0]), 32'd0);

    // Closing gap with a second PASS vehicle waiting
    s1_pulse(0); s1_pulse(0);
    s2_window(0, 2'b10); s2_window(0, 2'b10);
    chk("gap_qlvl2", 32'(q_level[1:0]), 32'd2);
    chk("gap_bar_open", 32'(barrier[0]), 32'd1);
    s3_pulse(0);
    chk("gap_bar_m", 32'(barrier[0]), 32'd0);
    chk("gap_qlvl1", 32'(q_level[1:0]), 32'd1);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk($sformatf("gap_closed_m%0d", j), 32'(barrier[0]), 32'd0);
    end
    step();
    chk("gap_reopen", 32'(barrier[0]), 32'd1);
    s3_pulse(0);
    chk("gap_drain_q", 32'(q_level[1:0]), 32'd0);
    chk("gap_drain_occ", 32'(occ[1:0]), 32'd0);

    // Invalid pass, no override
    s1_pulse(0); s2_window(0, 2'b01); step(); step();
    chk("fail_bar", 32'(barrier[0]), 32'd0);
    s3_pulse(0);
    chk("fail_cnt", 32'(fail_cnt[1:0]), 32'd1);
    chk("fail_pass_sat", 32'(pass_cnt[1:0]), 32'd3);
    chk("fail_err", 32'(err[0]), 32'd0);

    // Overflow, then push and pop together on a full queue
    repeat (3) s1_pulse(0);
    s2_window(0, 2'b10); s2_window(0, 2'b10); s2_window(0, 2'b10);
    chk("ovf_qlvl", 32'(q_level[1:0]), 32'd2);
    chk("ovf_err", 32'(err[0]), 32'd1);
    s2[0] = 1'b1; s3[0] = 1'b1; code[1:0] = 2'b10; step();
    code[1:0] = 2'b00; step();
    s2[0] = 1'b0; s3[0] = 1'b0; step();
    chk("full_pp_qlvl", 32'(q_level[1:0]), 32'd2);
    chk("full_pp_err", 32'(err[0]), 32'd1);
    chk("full_pp_fail", 32'(fail_cnt[1:0]), 32'd1);
    chk("full_pp_occ", 32'(occ[1:0]), 32'd2);
    s3_pulse(0); s3_pulse(0);
    chk("full_drain_q", 32'(q_level[1:0]), 32'd0);
    chk("full_drain_occ", 32'(occ[1:0]), 32'd0);

    // Lane 1: pop on an empty queue with a vehicle counted in the zone
    s1_pulse(1); s3_pulse(1);
    chk("empty_pop_err", 32'(err[1]), 32'd1);
    chk("empty_pop_cnts", 32'({pass_cnt[3:2], fail_cnt[3:2]}), 32'h1);
    chk("empty_pop_occ", 32'(occ[3:2]), 32'd0);

    // Lane 1: code changes 10 -> 01 inside one window keeps PASS
    s1_pulse(1);
    s2[1] = 1'b1; code[3:2] = 2'b10; step();
    code[3:2] = 2'b01; step();
    code[3:2] = 2'b00; s2[1] = 1'b0; step();
    chk("first_code_q", 32'(q_level[3:2]), 32'd1);
    s3_pulse(1);
    chk("first_code_pass", 32'(pass_cnt[3:2]), 32'd1);
    chk("first_code_fail", 32'(fail_cnt[3:2]), 32'd1);

    // Lane 1: counter saturation
    for (int v = 0; v < 5; v++) begin
      s1_pulse(1); s2_window(1, 2'b10); s3_pulse(1);
    end
    chk("sat_pass", 32'(pass_cnt[3:2]), 32'd3);
    chk("sat_fail", 32'(fail_cnt[3:2]), 32'd1);
    chk("lane0_untouched", 32'({pass_cnt[1:0], fail_cnt[1:0], q_level[1:0]}), 32'h34);

    // Reset with two vehicles queued
    s1_pulse(0); s1_pulse(0);
    s2_window(0, 2'b10); s2_window(0, 2'b10);
    chk("pre_rst_q", 32'(q_level[1:0]), 32'd2);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("rst_all", 32'({barrier, low_bal, err, q_level, occ, pass_cnt, fail_cnt}), 32'd0);
    s3_pulse(0);
    chk("rst_pop_err", 32'(err[0]), 32'd1);
    chk("rst_pop_cnts", 32'({pass_cnt[1:0], fail_cnt[1:0], q_level[1:0]}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
